// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-client round-robin arbiter and single initiator for the slow-memory line port
module mem_port_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err,
    output logic              busy
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state, state_nx;
    logic              gnt, gnt_nx;       // granted client: 0 = I, 1 = D
    logic              ptr, ptr_nx;       // round-robin preference: 0 = I, 1 = D
    logic [CW-1:0]     cnt, cnt_nx;
    logic              mem_read_nx, mem_write_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [DATA_W-1:0] mem_wdata_nx;
    logic [DATA_W-1:0] i_rdata_nx, d_rdata_nx;
    logic              i_ready_nx, d_ready_nx;
    logic              err_nx, busy_nx;
    logic              pend_i, pend_d, sel_d, op_write;

    assign pend_i   = i_read | i_write;
    assign pend_d   = d_read | d_write;
    assign sel_d    = pend_d & (~pend_i | ptr);
    assign op_write = sel_d ? d_write : i_write;

    always_comb begin
        state_nx     = state;
        gnt_nx       = gnt;
        ptr_nx       = ptr;
        cnt_nx       = cnt;
        mem_read_nx  = mem_read;
        mem_write_nx = mem_write;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        i_rdata_nx   = i_rdata;
        d_rdata_nx   = d_rdata;
        i_ready_nx   = 1'b0;
        d_ready_nx   = 1'b0;
        err_nx       = err;
        case (state)
            IDLE: begin
                if (pend_i | pend_d) begin
                    if (pend_i & pend_d) ptr_nx = ~ptr;
                    gnt_nx       = sel_d;
                    mem_addr_nx  = sel_d ? d_addr : i_addr;
                    mem_wdata_nx = sel_d ? d_wdata : i_wdata;
                    // a write beats a simultaneous read from the same client
                    mem_write_nx = op_write;
                    mem_read_nx  = ~op_write;
                    cnt_nx       = '0;
                    state_nx     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    mem_read_nx  = 1'b0;
                    mem_write_nx = 1'b0;
                    if (mem_read) begin
                        if (gnt) d_rdata_nx = mem_rdata;
                        else     i_rdata_nx = mem_rdata;
                    end
                    d_ready_nx = gnt;
                    i_ready_nx = ~gnt;
                    state_nx   = RESP;
                end else if (cnt == TO_LAST) begin
                    err_nx       = 1'b1;
                    mem_read_nx  = 1'b0;
                    mem_write_nx = 1'b0;
                    d_ready_nx   = gnt;
                    i_ready_nx   = ~gnt;
                    state_nx     = RESP;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx     = IDLE;
                mem_read_nx  = 1'b0;
                mem_write_nx = 1'b0;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            ptr       <= 1'b0;
            cnt       <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            gnt       <= gnt_nx;
            ptr       <= ptr_nx;
            cnt       <= cnt_nx;
            mem_read  <= mem_read_nx;
            mem_write <= mem_write_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            i_rdata   <= i_rdata_nx;
            d_rdata   <= d_rdata_nx;
            i_ready   <= i_ready_nx;
            d_ready   <= d_ready_nx;
            err       <= err_nx;
            busy      <= busy_nx;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, i_write, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] i_wdata, d_wdata, i_rdata, d_rdata;
    logic          i_ready, d_ready;
    logic          mem_read, mem_write, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          err, busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err(err), .busy(busy)
    );

    typedef struct {
        logic          cl;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_i, model_d;
    logic          model_err;
    int            passed = 0;
    int            total  = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    endtask

    task automatic push(input logic cl, input logic is_rd, input logic [DW-1:0] data);
        exp_t e;
        if (is_rd) begin
            if (cl) model_d = data;
            else    model_i = data;
        end
        e.cl    = cl;
        e.rdata = cl ? model_d : model_i;
        e.err   = model_err;
        sb.push_back(e);
    endtask

    task automatic check_ready();
        exp_t e;
        total++;
        assert (sb.size() > 0) passed++;
        else $error("FAIL sb_nonempty observed=%0d expected=>0", sb.size());
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("i_ready", i_ready, !e.cl);
            check("d_ready", d_ready, e.cl);
            if (e.cl) check("d_rdata", d_rdata, e.rdata);
            else      check("i_rdata", i_rdata, e.rdata);
            check("err", err, e.err);
            if (e.cl) begin d_read = 0; d_write = 0; end
            else      begin i_read = 0; i_write = 0; end
        end
        @(negedge clk);
        check("ready_one_cycle", {i_ready, d_ready}, 0);
        check("busy_idle", busy, 0);
    endtask

    task automatic mem_serve(input int lat, input logic [AW-1:0] addr, input logic wr,
                             input logic [DW-1:0] wdata, input logic [DW-1:0] rdata, input logic to);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_read | mem_write) && n < 20);
        check("req_seen", mem_read | mem_write, 1);
        check("mem_addr", mem_addr, addr);
        check("mem_write", mem_write, wr);
        check("mem_read", mem_read, !wr);
        if (wr) check("mem_wdata", mem_wdata, wdata);
        check("busy", busy, 1);
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) begin
                @(negedge clk);
                check("req_hold", {mem_read, mem_write}, {!wr, wr});
                check("addr_hold", mem_addr, addr);
            end
            if (k == lat && !to) begin
                mem_rdata = rdata;
                mem_ready = 1;
            end
        end
        @(negedge clk);
        mem_ready = 0;
        check("mem_drop", {mem_read, mem_write}, 0);
        check_ready();
    endtask

    initial begin
        logic [DW-1:0] pat_a5, pat_12, pat_b, pat_c, pat_d;
        pat_a5 = {16{8'hA5}};
        pat_12 = {8{16'h1234}};
        pat_b  = {4{32'hBEEF_0001}};
        pat_c  = {4{32'hC0DE_0002}};
        pat_d  = {4{32'hD00D_0003}};
        rst = 1; mem_ready = 0; mem_rdata = '0;
        i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
        d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
        model_i = '0; model_d = '0; model_err = 0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", {mem_read, mem_write}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_ready", {i_ready, d_ready}, 0);
        check("rst_rdata", i_rdata | d_rdata, 0);
        check("rst_err_busy", {err, busy}, 0);
        rst = 0;
        @(negedge clk);

        // single read, memory answers in cycle 6
        i_read = 1; i_addr = 28'h0000010;
        push(0, 1, pat_a5);
        mem_serve(6, 28'h0000010, 0, '0, pat_a5, 0);

        // single write; d_rdata must not pick up mem_rdata
        d_write = 1; d_addr = 28'h0000020; d_wdata = pat_12;
        push(1, 0, '0);
        mem_serve(3, 28'h0000020, 1, pat_12, {DW{1'b1}}, 0);

        // contention twice: I first, then D first
        i_read = 1; i_addr = 28'h0000030; d_read = 1; d_addr = 28'h0000031;
        push(0, 1, pat_b);
        push(1, 1, pat_c);
        mem_serve(2, 28'h0000030, 0, '0, pat_b, 0);
        mem_serve(4, 28'h0000031, 0, '0, pat_c, 0);
        i_read = 1; i_addr = 28'h0000032; d_read = 1; d_addr = 28'h0000033;
        push(1, 1, pat_d);
        push(0, 1, pat_a5);
        mem_serve(1, 28'h0000033, 0, '0, pat_d, 0);
        mem_serve(3, 28'h0000032, 0, '0, pat_a5, 0);

        // timeout, then err stays sticky across a normal transaction
        i_read = 1; i_addr = 28'h0000040;
        model_err = 1;
        push(0, 0, '0);
        mem_serve(TO, 28'h0000040, 0, '0, '0, 1);
        d_read = 1; d_addr = 28'h0000041;
        push(1, 1, pat_b);
        mem_serve(2, 28'h0000041, 0, '0, pat_b, 0);

        // read and write together: write wins
        d_read = 1; d_write = 1; d_addr = 28'h0000050; d_wdata = pat_c;
        push(1, 0, '0);
        mem_serve(2, 28'h0000050, 1, pat_c, pat_d, 0);

        // reset in the 3rd ISSUE cycle aborts without a ready
        i_read = 1; i_addr = 28'h0000060;
        repeat (3) @(negedge clk);
        check("pre_rst_read", mem_read, 1);
        rst = 1;
        #1;
        check("abort_mem_read", mem_read, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", {i_ready, d_ready}, 0);
        check("abort_err", err, 0);
        model_i = '0; model_d = '0; model_err = 0;
        i_read = 0;
        @(negedge clk);
        rst = 0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_quiet", {i_ready, d_ready, busy}, 0);
        end
        i_read = 1; i_addr = 28'h0000070;
        push(0, 1, pat_12);
        mem_serve(3, 28'h0000070, 0, '0, pat_12, 0);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
